// File: rtl/urisc_pkg.sv
// Shared definitions for the subleq (a,b,c) core: word width, instruction
// field bounds, the word type and the three execution phases.
package urisc_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int INSTR_SIZE = 3 * WORD_SIZE;

  // Instruction layout, most significant field first: {a, b, c}
  localparam int A_UB = INSTR_SIZE - 1;
  localparam int A_LB = 2 * WORD_SIZE;
  localparam int B_UB = 2 * WORD_SIZE - 1;
  localparam int B_LB = WORD_SIZE;
  localparam int C_UB = WORD_SIZE - 1;
  localparam int C_LB = 0;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    OPERAND = 2'd1,
    EXECUTE = 2'd2
  } phase_e;

endpackage

// File: rtl/phase_sequencer.sv
// Modulo-DIVIDE_BY phase counter with a one-hot strobe per phase, so the core
// advances through FETCH/OPERAND/EXECUTE without leaving the clk domain.
module phase_sequencer #(
  parameter int DIVIDE_BY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [DIVIDE_BY-1:0] phase_en
);

  localparam int CW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDE_BY - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count + CW'(1);
    if (count == LAST) begin
      count_next = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign phase_en = DIVIDE_BY'(1) << count;

endmodule

// File: rtl/urisc_memory.sv
// Dual-port, read-first word memory plus the phase sequencer for the subleq core.
// Optional `collision` output when URISC_MEM_COLLISION_EN is defined.
module urisc_memory
  import urisc_pkg::*;
#(
  parameter int    WORD_SIZE = urisc_pkg::WORD_SIZE,
  parameter int    DEPTH     = 256,
  parameter int    DIVIDE_BY = 3,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] add1,
  input  logic [WORD_SIZE-1:0] dataIn1,
  input  logic                 write1,
  output logic [WORD_SIZE-1:0] dataOut1,
  input  logic [WORD_SIZE-1:0] add2,
  input  logic [WORD_SIZE-1:0] dataIn2,
  input  logic                 write2,
  output logic [WORD_SIZE-1:0] dataOut2,
  output logic [DIVIDE_BY-1:0] phase_en
`ifdef URISC_MEM_COLLISION_EN
  ,
  output logic                 collision
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        idx1;
  logic [AW-1:0]        idx2;
  logic                 same_write;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH.
  assign idx1       = add1[AW-1:0];
  assign idx2       = add2[AW-1:0];
  assign same_write = write1 && write2 && (idx1 == idx2);

  if (WORD_SIZE > AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{add1[WORD_SIZE-1:AW], add2[WORD_SIZE-1:AW]};
  end

  // NOTE: the array itself is never reset, which lets it map onto block RAM;
  // reset only gates writes and clears the output registers below.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (write2 && !same_write) begin
        mem[idx2] <= dataIn2;
      end
      if (write1) begin
        mem[idx1] <= dataIn1;
      end
    end
  end

  // Reads sample the array before this edge's writes land: read-first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dataOut1 <= '0;
      dataOut2 <= '0;
    end else begin
      dataOut1 <= mem[idx1];
      dataOut2 <= mem[idx2];
    end
  end

`ifdef URISC_MEM_COLLISION_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      collision <= 1'b0;
    end else begin
      collision <= same_write;
    end
  end
`endif

  phase_sequencer #(
    .DIVIDE_BY(DIVIDE_BY)
  ) u_phase_sequencer (
    .clk     (clk),
    .rst     (rst),
    .phase_en(phase_en)
  );

endmodule

// File: tb/tb_urisc_memory.sv
// Scoreboard bench for urisc_memory: a reference memory and phase counter
// produce expected values at drive time, compared after each posedge.
module tb_urisc_memory;

  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int DIV   = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   add1, dataIn1, add2, dataIn2;
  logic           write1, write2;
  logic [W-1:0]   dataOut1, dataOut2;
  logic [DIV-1:0] phase_en;
`ifdef URISC_MEM_COLLISION_EN
  logic           collision;
`endif

  urisc_memory #(
    .WORD_SIZE(W),
    .DEPTH    (DEPTH),
    .DIVIDE_BY(DIV),
    .INIT_FILE("")
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .add1    (add1),
    .dataIn1 (dataIn1),
    .write1  (write1),
    .dataOut1(dataOut1),
    .add2    (add2),
    .dataIn2 (dataIn2),
    .write2  (write2),
    .dataOut2(dataOut2),
    .phase_en(phase_en)
`ifdef URISC_MEM_COLLISION_EN
    ,
    .collision(collision)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   d1;
    bit             v1;
    logic [W-1:0]   d2;
    bit             v2;
    logic [DIV-1:0] ph;
    logic           coll;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [DEPTH];
  bit           valid [DEPTH];
  int           ph_cnt = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst_v, input logic w1, input logic [W-1:0] a1,
                       input logic [W-1:0] d1, input logic w2, input logic [W-1:0] a2,
                       input logic [W-1:0] d2);
    exp_t e;
    int   i1, i2;
    bit   same;
    @(negedge clk);
    rst = rst_v; write1 = w1; add1 = a1; dataIn1 = d1;
    write2 = w2; add2 = a2; dataIn2 = d2;
    i1   = int'(a1 % DEPTH);
    i2   = int'(a2 % DEPTH);
    same = w1 && w2 && (i1 == i2);
    if (!rst_v) begin
      e.d1 = '0; e.v1 = 1'b1; e.d2 = '0; e.v2 = 1'b1; e.coll = 1'b0;
      ph_cnt = 0;
    end else begin
      e.d1 = model[i1]; e.v1 = valid[i1];
      e.d2 = model[i2]; e.v2 = valid[i2];
      e.coll = same;
      ph_cnt = (ph_cnt + 1) % DIV;
      if (w2 && !same) begin model[i2] = d2; valid[i2] = 1'b1; end
      if (w1) begin model[i1] = d1; valid[i1] = 1'b1; end
    end
    e.ph = DIV'(1) << ph_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.v1) check("dataOut1", dataOut1, e.d1);
    if (e.v2) check("dataOut2", dataOut2, e.d2);
    check("phase_en", W'(phase_en), W'(e.ph));
`ifdef URISC_MEM_COLLISION_EN
    check("collision", W'(collision), W'(e.coll));
`endif
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b0; write1 = 1'b0; write2 = 1'b0;
    add1 = '0; add2 = '0; dataIn1 = '0; dataIn2 = '0;

    // Reset held two cycles, then rotation 001,010,100,001
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    repeat (4) idle();

    // Write on port 1, read back on port 2 the next cycle
    cycle(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, '0);
    cycle(1'b1, 1'b0, 32'd5, '0, 1'b0, 32'd5, '0);

    // Read-first across ports
    cycle(1'b1, 1'b1, 32'd7, 32'd1, 1'b0, 32'd0, '0);
    cycle(1'b1, 1'b1, 32'd7, 32'd9, 1'b0, 32'd7, '0);
    cycle(1'b1, 1'b0, 32'd0, '0, 1'b0, 32'd7, '0);

    // Read-first on the same port
    cycle(1'b1, 1'b0, 32'd0, '0, 1'b1, 32'd7, 32'd11);
    cycle(1'b1, 1'b0, 32'd7, '0, 1'b0, 32'd7, '0);

    // Dual write to one address: port 1 wins
    cycle(1'b1, 1'b1, 32'd3, 32'hAAAA_AAAA, 1'b1, 32'd3, 32'hBBBB_BBBB);
    cycle(1'b1, 1'b0, 32'd3, '0, 1'b0, 32'd3, '0);
    // Dual write, distinct addresses: both land
    cycle(1'b1, 1'b1, 32'd10, 32'h1010, 1'b1, 32'd11, 32'h1111);
    cycle(1'b1, 1'b0, 32'd11, '0, 1'b0, 32'd10, '0);
    // Collision through address wrap on port 2
    cycle(1'b1, 1'b1, 32'd12, 32'hC1, 1'b1, 32'd268, 32'hC2);
    cycle(1'b1, 1'b0, 32'd12, '0, 1'b0, 32'd12, '0);

    // Address wrap
    cycle(1'b1, 1'b1, 32'd260, 32'h55, 1'b0, 32'd0, '0);
    cycle(1'b1, 1'b0, 32'hFFFF_FF04, '0, 1'b0, 32'd4, '0);
    cycle(1'b1, 1'b0, 32'd0, '0, 1'b1, 32'd255, 32'hFF);
    cycle(1'b1, 1'b0, 32'hFFFF_FFFF, '0, 1'b0, 32'd511, '0);

    // Reset mid-rotation with a write that must be ignored
    for (int i = 0; i < 4 && ph_cnt != 1; i++) idle();
    check("phase before reset", W'(phase_en), W'(3'b010));
    cycle(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'd3, 32'd0);
    idle();
    cycle(1'b1, 1'b0, 32'd5, '0, 1'b0, 32'd3, '0);

    // Random traffic over a small address window with random upper bits
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 1)), {$urandom_range(0, 255), 4'($urandom_range(0, 15))}, $urandom(),
            1'($urandom_range(0, 1)), {$urandom_range(0, 255), 4'($urandom_range(0, 15))}, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
